// File: rtl/control_pkg.sv
// Shared encodings for the accumulator machine's sequencer: opcodes, sequencer states, ALU selects.
// Build option CTRL_HALT_EN adds the HALT state and gives opcode 1111 the HLT meaning.
package control_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_STA = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_JZ  = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10
  } alu_op_e;

`ifdef CTRL_HALT_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_e;
`endif

endpackage

// File: rtl/control_unit.sv
// Instruction sequencer: 3 cycles for NOP/STA/JMP/JZ/illegal, 4 for LDA/ADD/SUB; run=0 only stops at retire or IDLE.
// Outputs decode from state and opcode only; CTRL_HALT_EN enables HLT (1111) and the sticky HALT state.
module control_unit
  import control_pkg::*;
#(
  parameter int ICNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        opcode,
  input  logic              zero,
  output logic              LoadIR,
  output logic              IncPC,
  output logic              LoadPC,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              LoadAcc,
  output logic              addr_sel,
  output logic [1:0]        alu_op,
  output logic              halted,
  output logic              illegal_op,
  output logic [ICNT_W-1:0] instr_count
);

  state_e            state_q, state_d;
  logic [ICNT_W-1:0] instr_count_q, instr_count_d;
  logic              retire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    LoadIR     = 1'b0;
    IncPC      = 1'b0;
    LoadPC     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    LoadAcc    = 1'b0;
    addr_sel   = 1'b0;
    alu_op     = ALU_PASS;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        MemRead = 1'b1;
        LoadIR  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        IncPC   = 1'b1;
        state_d = EXEC;
`ifdef CTRL_HALT_EN
        if (opcode == OP_HLT) state_d = HALT;
`endif
      end
      EXEC: begin
        retire = 1'b1;
        case (opcode)
          OP_NOP: begin
          end
          OP_LDA, OP_ADD, OP_SUB: begin
            addr_sel = 1'b1;
            MemRead  = 1'b1;
            retire   = 1'b0;
            state_d  = WB;
          end
          OP_STA: begin
            addr_sel = 1'b1;
            MemWrite = 1'b1;
          end
          OP_JMP: LoadPC = 1'b1;
          OP_JZ:  LoadPC = zero;
          // Unknown opcodes retire like NOP; the flag lasts only this EXEC cycle.
          default: illegal_op = 1'b1;
        endcase
      end
      WB: begin
        LoadAcc = 1'b1;
        retire  = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
      end
`ifdef CTRL_HALT_EN
      HALT: halted = 1'b1;
`endif
      default: state_d = IDLE;
    endcase

    if (retire) state_d = run ? FETCH : IDLE;
  end

  assign instr_count_d = retire ? instr_count_q + ICNT_W'(1) : instr_count_q;
  assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors against hand-built expectations.
// Define CTRL_HALT_EN for both bench and RTL to exercise the HLT path.
module tb_control_unit;
  import control_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       zero  = 1'b0;
  logic       LoadIR, IncPC, LoadPC, MemRead, MemWrite, LoadAcc, addr_sel;
  logic [1:0] alu_op;
  logic       halted, illegal_op;
  logic [7:0] instr_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Bit order: LoadIR IncPC LoadPC MemRead MemWrite LoadAcc addr_sel alu_op[1:0] halted illegal_op
  logic [10:0] outs;
  assign outs = {LoadIR, IncPC, LoadPC, MemRead, MemWrite, LoadAcc, addr_sel, alu_op, halted, illegal_op};

  localparam logic [10:0] E_IDLE    = 11'd0;
  localparam logic [10:0] E_FETCH   = (11'd1 << 10) | (11'd1 << 7);
  localparam logic [10:0] E_DECODE  = (11'd1 << 9);
  localparam logic [10:0] E_RD      = (11'd1 << 7) | (11'd1 << 4);
  localparam logic [10:0] E_STA     = (11'd1 << 6) | (11'd1 << 4);
  localparam logic [10:0] E_JMP     = (11'd1 << 8);
  localparam logic [10:0] E_ILL     = 11'd1;
  localparam logic [10:0] E_WB_PASS = (11'd1 << 5);
  localparam logic [10:0] E_WB_ADD  = (11'd1 << 5) | (11'd1 << 2);
  localparam logic [10:0] E_WB_SUB  = (11'd1 << 5) | (11'd2 << 2);
  localparam logic [10:0] E_HALT    = (11'd1 << 1);

  control_unit #(.ICNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .opcode      (opcode),
    .zero        (zero),
    .LoadIR      (LoadIR),
    .IncPC       (IncPC),
    .LoadPC      (LoadPC),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .LoadAcc     (LoadAcc),
    .addr_sel    (addr_sel),
    .alu_op      (alu_op),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    run = 1'b0; opcode = OP_LDA; zero = 1'b0;
    #1 reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (outs !== E_IDLE || instr_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state outs=%b cnt=%0d want outs=%b cnt=0", outs, instr_count, E_IDLE);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if (outs !== E_IDLE || instr_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_run0 outs=%b cnt=%0d want outs=%b cnt=0", outs, instr_count, E_IDLE);
    end
    run = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if (outs !== E_RD) begin
      tests_failed++;
      $display("FAIL lda_exec_pre_reset outs=%b want %b", outs, E_RD);
    end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if (outs !== E_IDLE || instr_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_exec outs=%b cnt=%0d want outs=%b cnt=0", outs, instr_count, E_IDLE);
    end
    run = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if (outs !== E_IDLE || instr_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_after_release outs=%b cnt=%0d want outs=%b cnt=0", outs, instr_count, E_IDLE);
    end
  endtask

  task automatic test_lda_add();
    logic [10:0] exp [8] = '{E_FETCH, E_DECODE, E_RD, E_WB_PASS, E_FETCH, E_DECODE, E_RD, E_WB_ADD};
    run = 1'b1; opcode = OP_LDA;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL lda_add cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 4) opcode = OP_ADD;
      if (k == 7) run = 1'b0;
    end
    @(negedge clock);
    tests_run++;
    if (outs !== E_IDLE || instr_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL lda_add_end outs=%b cnt=%0d want outs=%b cnt=2", outs, instr_count, E_IDLE);
    end
  endtask

  task automatic test_jz();
    logic [10:0] exp [7] = '{E_FETCH, E_DECODE, E_IDLE, E_FETCH, E_DECODE, E_JMP, E_IDLE};
    run = 1'b1; opcode = OP_JZ; zero = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL jz cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 3) zero = 1'b1;
      if (k == 5) run = 1'b0;
    end
    zero = 1'b0;
    tests_run++;
    if (instr_count !== 8'd4) begin
      tests_failed++;
      $display("FAIL jz_count cnt=%0d want 4", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp [11] = '{E_FETCH, E_DECODE, E_RD, E_WB_SUB, E_FETCH, E_DECODE, E_STA,
                              E_FETCH, E_DECODE, E_JMP, E_IDLE};
    run = 1'b1; opcode = OP_SUB;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL back_to_back cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 4) opcode = OP_STA;
      if (k == 7) opcode = OP_JMP;
      if (k == 9) run = 1'b0;
    end
    tests_run++;
    if (instr_count !== 8'd7) begin
      tests_failed++;
      $display("FAIL back_to_back_count cnt=%0d want 7", instr_count);
    end
  endtask

  task automatic test_illegal();
    logic [10:0] exp [7] = '{E_FETCH, E_DECODE, E_ILL, E_FETCH, E_DECODE, E_IDLE, E_IDLE};
    logic [3:0] bad_op = 4'b1010;
    run = 1'b1; opcode = bad_op;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL illegal cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 3) begin
        tests_run++;
        if (instr_count !== 8'd8) begin
          tests_failed++;
          $display("FAIL illegal_count cnt=%0d want 8", instr_count);
        end
        opcode = OP_NOP;
        run = 1'b0;
      end
    end
    tests_run++;
    if (instr_count !== 8'd9) begin
      tests_failed++;
      $display("FAIL illegal_nop_count cnt=%0d want 9", instr_count);
    end
  endtask

  task automatic test_run_drop();
    logic [10:0] exp [5] = '{E_FETCH, E_DECODE, E_STA, E_IDLE, E_IDLE};
    run = 1'b1; opcode = OP_STA;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL run_drop cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 1) run = 1'b0;
    end
    tests_run++;
    if (instr_count !== 8'd10) begin
      tests_failed++;
      $display("FAIL run_drop_count cnt=%0d want 10", instr_count);
    end
  endtask

  task automatic test_halt();
`ifdef CTRL_HALT_EN
    logic [10:0] exp [8] = '{E_FETCH, E_DECODE, E_HALT, E_HALT, E_HALT, E_HALT, E_HALT, E_HALT};
    run = 1'b1; opcode = OP_HLT;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL halt cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 3) run = 1'b0;
      if (k == 5) run = 1'b1;
    end
    tests_run++;
    if (instr_count !== 8'd10) begin
      tests_failed++;
      $display("FAIL halt_count cnt=%0d want 10", instr_count);
    end
    run = 1'b0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (outs !== E_IDLE || instr_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL halt_reset outs=%b cnt=%0d want outs=%b cnt=0", outs, instr_count, E_IDLE);
    end
    @(negedge clock);
    reset = 1'b1;
`else
    logic [10:0] exp [7] = '{E_FETCH, E_DECODE, E_ILL, E_FETCH, E_DECODE, E_IDLE, E_IDLE};
    run = 1'b1; opcode = OP_HLT;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      tests_run++;
      if (outs !== exp[k]) begin
        tests_failed++;
        $display("FAIL hlt_as_illegal cycle%0d outs=%b want %b", k + 1, outs, exp[k]);
      end
      if (k == 3) begin
        opcode = OP_NOP;
        run = 1'b0;
      end
    end
    tests_run++;
    if (instr_count !== 8'd12) begin
      tests_failed++;
      $display("FAIL hlt_as_illegal_count cnt=%0d want 12", instr_count);
    end
`endif
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    #1;
    tests_run++;
    if (instr_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL wrap_reset cnt=%0d want 0", instr_count);
    end
    @(negedge clock);
    reset = 1'b1;
    run = 1'b1; opcode = OP_NOP;
    for (int k = 0; k < 768; k++) begin
      @(negedge clock);
      if (k == 765) begin
        tests_run++;
        if (instr_count !== 8'd255 || outs !== E_FETCH) begin
          tests_failed++;
          $display("FAIL wrap_255 cnt=%0d outs=%b want cnt=255 outs=%b", instr_count, outs, E_FETCH);
        end
      end
      if (k == 766) run = 1'b0;
    end
    @(negedge clock);
    tests_run++;
    if (instr_count !== 8'd0 || outs !== E_IDLE) begin
      tests_failed++;
      $display("FAIL wrap_to_zero cnt=%0d outs=%b want cnt=0 outs=%b", instr_count, outs, E_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_lda_add();
    test_jz();
    test_back_to_back();
    test_illegal();
    test_run_drop();
    test_halt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter ICNT_W, default 8, meaning the width of the retired-instruction counter.
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port run, input, 1, enables instruction sequencing.
REQ-005 The block SHALL have port opcode, input, 4, the opcode field from the instruction register; valid from DECODE onward.
REQ-006 The block SHALL have port zero, input, 1, the accumulator-zero flag, used by JZ.
REQ-007 The block SHALL have outputs LoadIR, IncPC, LoadPC, MemRead, MemWrite, LoadAcc and addr_sel, each 1 bit; addr_sel 0 selects PC and 1 selects the IR data field.
REQ-008 The block SHALL have output alu_op, 2 bits: 00 PASS, 01 ADD, 10 SUB.
REQ-009 The block SHALL have outputs halted (1 bit), illegal_op (1 bit) and instr_count (ICNT_W bits).

Function
REQ-010 States SHALL be IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-011 Control outputs SHALL be combinational decodes of the current state and opcode only; all outputs not listed for a state are 0.
REQ-012 In IDLE, the unit SHALL go to FETCH when run=1, else stay in IDLE.
REQ-013 In FETCH, the unit SHALL drive addr_sel=0, MemRead=1 and LoadIR=1, then go to DECODE.
REQ-014 In DECODE, the unit SHALL drive IncPC=1, then go to EXEC; with CTRL_HALT_EN, HLT goes to HALT instead.
REQ-015 EXEC, opcode 0000 NOP: no outputs; instruction retires.
REQ-016 EXEC, opcode 0001 LDA: addr_sel=1, MemRead=1, next state WB.
REQ-017 EXEC, opcode 0010 STA: addr_sel=1, MemWrite=1; instruction retires.
REQ-018 EXEC, opcodes 0011 ADD and 0100 SUB: addr_sel=1, MemRead=1, next state WB.
REQ-019 EXEC, opcode 0101 JMP: LoadPC=1; instruction retires.
REQ-020 EXEC, opcode 0110 JZ: LoadPC=zero, as sampled in EXEC; instruction retires.
REQ-021 EXEC, any other opcode SHALL behave as NOP and pulse illegal_op for exactly that one cycle.
REQ-022 In WB, the unit SHALL drive LoadAcc=1 with alu_op = PASS for LDA, ADD for ADD and SUB for SUB, then retire the instruction.
REQ-023 Retire SHALL mean: increment instr_count on that edge and go to FETCH if run=1, else IDLE.
REQ-024 Latency SHALL be 3 cycles for NOP/STA/JMP/JZ/illegal and 4 cycles for LDA/ADD/SUB.
REQ-025 run=0 SHALL be honoured only at retirement or in IDLE; an instruction in flight SHALL always complete.
REQ-026 instr_count SHALL wrap from 2^ICNT_W-1 to 0 without saturating or flagging.
REQ-027 In HALT, the unit SHALL drive halted=1 and all control outputs 0, and remain there until reset, regardless of run.

Reset
REQ-028 Assertion of reset (low) SHALL immediately force state to IDLE and instr_count to 0, so that every output reads 0, including during mid-instruction.
REQ-029 After reset deassertion, the first FETCH SHALL occur on the first rising edge at which run=1.

Configuration
REQ-030 With CTRL_HALT_EN defined, opcode 1111 SHALL be HLT: DECODE goes to HALT, and HLT does not increment instr_count.
REQ-031 Without CTRL_HALT_EN, the HALT state SHALL not exist, halted SHALL be tied 0, and 1111 SHALL be treated as illegal (REQ-021).

Structure
REQ-032 Package control_pkg SHALL hold the opcode constants, the state enumeration type and the alu_op encodings; instruction_register and the datapath import the same package.
REQ-033 The block SHALL have no sub-module; next-state logic, output decode and counter are in a single module.

Verification
REQ-034 Reset and idle check: reset low mid-EXEC of an LDA -> all outputs 0 immediately; with run=0 after release, the unit stays in IDLE and instr_count=0.
REQ-035 LDA then ADD with run=1 -> LoadIR in cycles 1 and 5, LoadAcc with alu_op=00 in cycle 4 and 01 in cycle 8, instr_count=2.
REQ-036 JZ with zero=0 -> LoadPC stays 0; JZ with zero=1 -> LoadPC=1 for exactly the EXEC cycle.
REQ-037 opcode 1010 -> illegal_op high for one cycle, instr_count increments, next state FETCH.
REQ-038 run dropped during DECODE of STA -> MemWrite still pulses, then IDLE; 256 NOPs -> instr_count returns to 0.
REQ-039 HLT with CTRL_HALT_EN -> halted=1 from the cycle after DECODE, persistent until reset; HLT without the macro -> illegal_op pulse and sequencing continues.
